instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch unit that drives the address side of the instruction memory's single asynchronous read port and delivers fetched words to decode over a valid/ready handshake. It holds the program counter and sequences it: increment, wrap-around, branch redirect, stall on backpressure, and halt on a dedicated halt word. It sits between the instruction memory (256 x 32, combinational read) and the decode stage.

## Interface
- ADDR_W, 8, instruction address width; the memory depth is 2^ADDR_W.
- DATA_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded at reset and on restart.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins fetching, or restarts it from the HALTED state.
- inst_address  output  ADDR_W  address to the instruction memory; equals the PC register.
- read_data  input  DATA_W  word returned by the memory in the same cycle.
- instr_out  output  DATA_W  registered instruction presented to decode.
- instr_pc  output  ADDR_W  address instr_out was fetched from.
- instr_valid  output  1  instr_out holds an unconsumed instruction.
- instr_ready  input  1  decode accepts instr_out this cycle.
- branch_taken  input  1  redirect request (one cycle).
- branch_target  input  ADDR_W  new PC value when branch_taken is asserted.
- halted  output  1  high while state is HALTED.
- fetch_count  output  16  count of completed handshakes; saturates at 16'hFFFF.

## Operation
- States: IDLE, FETCH, HALTED.
- Reset values: state=IDLE, pc=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0.
- Definitions:
  - handshake = instr_valid & instr_ready.
  - slot_free = !instr_valid | handshake.
- IDLE:
  - start moves the state to FETCH.
  - branch_taken is ignored.
- FETCH, with no branch and slot_free:
  - instr_out <= read_data, instr_pc <= pc, instr_valid <= 1.
  - If read_data == HALT_WORD: pc is held and the state moves to HALTED. The halt word itself is still delivered to decode.
  - Otherwise pc <= pc + 1 modulo 2^ADDR_W (255 wraps to 0).
- FETCH, no branch, !slot_free (stall): pc, instr_out, instr_pc and instr_valid all hold.
- FETCH, branch_taken (has priority over fetch):
  - pc <= branch_target.
  - instr_valid <= 0, which flushes the held word whether or not it was consumed this cycle.
  - No capture of read_data happens in that cycle.
- HALTED:
  - No capture. instr_valid clears on the handshake of the halt word.
  - start sets pc <= RESET_PC and moves the state to FETCH; any pending valid word is flushed.
  - branch_taken is ignored.
- fetch_count increments on every handshake, including a handshake in the same cycle as a branch, and saturates at 16'hFFFF.
- Reset asserted mid-operation returns everything to the reset values immediately (asynchronous). Any in-flight instruction is lost.

## Timing
- inst_address is driven directly from the pc register, with no combinational path from any input.
- Latency:
  - start sampled at edge N → FETCH after edge N.
  - First word captured at edge N+1, so instr_valid is high in cycle N+1.
- Throughput is one instruction per cycle while instr_ready is held high.
- Branch at edge M: instr_valid is low in cycle M, and the word at branch_target is valid after edge M+1, giving a 1-cycle bubble.
- instr_out and instr_pc stay stable while instr_valid=1 and instr_ready=0.
- halted rises the cycle after the halt word is captured.

## Test plan
- Sequential fetch: memory holds word i = 32'h1000_0000+i; start, instr_ready=1 → instr_pc runs 0,1,2,… on consecutive cycles, instr_out = 32'h1000_0000+instr_pc, fetch_count = 5 after 5 handshakes.
- Backpressure: hold instr_ready=0 for 3 cycles with instr_pc=4 valid → instr_out, instr_pc and inst_address (5) frozen; on release, instr_pc 4 then 5 with no skip and no duplicate.
- Wrap: branch_taken with target 8'hFE, ready=1 → instr_pc sequence FE, FF, 00, 01.
- Branch + handshake together: instr_pc=10 valid, ready=1, branch_taken with target 8'h40 → fetch_count increments, instr_valid=0 for one cycle, next instr_pc=8'h40.
- Halt: ram[3]=32'hFFFF_FFFF → words 0..3 delivered, halted=1, inst_address stays 3, no instr_valid after the handshake of word 3; start → instr_pc restarts at 0.
- Reset mid-stream: assert rst while instr_valid=1 and pc=7 → all outputs return to reset values without waiting for a clock edge; fetch resumes only after a new start.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequences the PC, captures words from a combinational
// instruction memory and hands them to decode over a valid/ready handshake.
module instruction_fetch #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] inst_address,
   input  logic [DATA_W-1:0] read_data,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              halted,
   output logic [15:0]       fetch_count
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HALTED
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_inc_d;
   logic [DATA_W-1:0] instr_q;
   logic [ADDR_W-1:0] ipc_q;
   logic              valid_q;
   logic              halted_q;
   logic [15:0]       cnt_q;
   logic              hs;
   logic              slot_free;
   logic              is_halt;

   always_comb begin
      hs        = valid_q & instr_ready;
      slot_free = !valid_q | hs;
      is_halt   = (read_data == HALT_WORD);
      pc_inc_d  = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         ipc_q    <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (hs && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
         end
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               // A redirect discards the held word even if it is being consumed.
               if (branch_taken) begin
                  pc_q    <= branch_target;
                  valid_q <= 1'b0;
               end else if (slot_free) begin
                  instr_q <= read_data;
                  ipc_q   <= pc_q;
                  valid_q <= 1'b1;
                  if (is_halt) begin
                     state_q  <= HALTED;
                     halted_q <= 1'b1;
                  end else begin
                     pc_q <= pc_inc_d;
                  end
               end
            end
            HALTED: begin
               if (start) begin
                  pc_q     <= RESET_PC;
                  valid_q  <= 1'b0;
                  halted_q <= 1'b0;
                  state_q  <= FETCH;
               end else if (hs) begin
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign inst_address = pc_q;
   assign instr_out    = instr_q;
   assign instr_pc     = ipc_q;
   assign instr_valid  = valid_q;
   assign halted       = halted_q;
   assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural model checked every cycle plus
// directed scenarios with literal expectations.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  inst_address;
   logic [31:0] read_data;
   logic [31:0] instr_out;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic [7:0]  branch_target = 8'h00;
   logic        halted;
   logic [15:0] fetch_count;

   logic [31:0] ram [256];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign read_data = ram[inst_address];

   instruction_fetch dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .inst_address(inst_address),
      .read_data(read_data),
      .instr_out(instr_out),
      .instr_pc(instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .halted(halted),
      .fetch_count(fetch_count)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Model: 0 = idle, 1 = fetching, 2 = halted
   int          m_mode = 0;
   logic [7:0]  m_pc = 8'h00;
   logic [31:0] m_out = 32'h0;
   logic [7:0]  m_ipc = 8'h00;
   bit          m_v = 1'b0;
   int          m_cnt = 0;

   task automatic model_reset();
      m_mode = 0;
      m_pc = 8'h00;
      m_out = 32'h0;
      m_ipc = 8'h00;
      m_v = 1'b0;
      m_cnt = 0;
   endtask

   task automatic model_step();
      bit take;
      logic [31:0] w;
      take = m_v && instr_ready;
      if (take && m_cnt < 65535) m_cnt++;
      if (m_mode == 0) begin
         if (start) m_mode = 1;
      end else if (m_mode == 1) begin
         if (branch_taken) begin
            m_pc = branch_target;
            m_v = 1'b0;
         end else if (!m_v || take) begin
            w = ram[m_pc];
            m_out = w;
            m_ipc = m_pc;
            m_v = 1'b1;
            if (w == 32'hFFFF_FFFF) m_mode = 2;
            else m_pc = m_pc + 8'd1;
         end
      end else begin
         if (start) begin
            m_pc = 8'h00;
            m_v = 1'b0;
            m_mode = 1;
         end else if (take) begin
            m_v = 1'b0;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
         #1;
         chk("m_addr", {24'h0, inst_address}, {24'h0, m_pc});
         chk("m_valid", {31'h0, instr_valid}, {31'h0, m_v});
         chk("m_halted", {31'h0, halted}, {31'h0, (m_mode == 2)});
         chk("m_count", {16'h0, fetch_count}, m_cnt[31:0]);
         if (m_v) begin
            chk("m_out", instr_out, m_out);
            chk("m_pc", {24'h0, instr_pc}, {24'h0, m_ipc});
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   int c0;

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h1000_0000 + i;
      cyc(2);
      chk("rst_addr", {24'h0, inst_address}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_out", instr_out, 32'h0);
      chk("rst_count", {16'h0, fetch_count}, 32'h0);
      rst = 1'b0;
      cyc(3);
      chk("idle_valid", {31'h0, instr_valid}, 32'h0);

      // Sequential fetch
      instr_ready = 1'b1;
      pulse_start();
      cyc(1);
      chk("seq_first_pc", {24'h0, instr_pc}, 32'h0);
      chk("seq_first_v", {31'h0, instr_valid}, 32'h1);
      cyc(5);
      chk("seq_count5", {16'h0, fetch_count}, 32'd5);
      chk("seq_pc5", {24'h0, instr_pc}, 32'd5);
      chk("seq_out5", instr_out, 32'h1000_0005);

      // Backpressure
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("bp_pc", {24'h0, instr_pc}, 32'd5);
         chk("bp_out", instr_out, 32'h1000_0005);
         chk("bp_addr", {24'h0, inst_address}, 32'd6);
         chk("bp_count", {16'h0, fetch_count}, 32'd5);
      end
      instr_ready = 1'b1;
      cyc(1);
      chk("bp_rel_pc", {24'h0, instr_pc}, 32'd6);
      chk("bp_rel_count", {16'h0, fetch_count}, 32'd6);

      // Wrap-around
      branch_taken = 1'b1;
      branch_target = 8'hFE;
      cyc(1);
      branch_taken = 1'b0;
      chk("wrap_bubble", {31'h0, instr_valid}, 32'h0);
      cyc(1);
      chk("wrap_fe", {24'h0, instr_pc}, 32'hFE);
      cyc(1);
      chk("wrap_ff", {24'h0, instr_pc}, 32'hFF);
      cyc(1);
      chk("wrap_00", {24'h0, instr_pc}, 32'h00);
      chk("wrap_00_out", instr_out, 32'h1000_0000);
      cyc(1);
      chk("wrap_01", {24'h0, instr_pc}, 32'h01);

      // Branch coinciding with a handshake
      branch_taken = 1'b1;
      branch_target = 8'h08;
      cyc(1);
      branch_taken = 1'b0;
      cyc(3);
      chk("bh_pc10", {24'h0, instr_pc}, 32'd10);
      c0 = int'(fetch_count);
      branch_taken = 1'b1;
      branch_target = 8'h40;
      cyc(1);
      branch_taken = 1'b0;
      chk("bh_count", {16'h0, fetch_count}, c0 + 1);
      chk("bh_bubble", {31'h0, instr_valid}, 32'h0);
      cyc(1);
      chk("bh_pc40", {24'h0, instr_pc}, 32'h40);
      chk("bh_v40", {31'h0, instr_valid}, 32'h1);

      // Halt word
      rst = 1'b1;
      cyc(1);
      ram[3] = 32'hFFFF_FFFF;
      rst = 1'b0;
      pulse_start();
      cyc(4);
      chk("halt_h", {31'h0, halted}, 32'h1);
      chk("halt_pc", {24'h0, instr_pc}, 32'd3);
      chk("halt_out", instr_out, 32'hFFFF_FFFF);
      chk("halt_addr", {24'h0, inst_address}, 32'd3);
      cyc(1);
      chk("halt_drain", {31'h0, instr_valid}, 32'h0);
      branch_taken = 1'b1;
      branch_target = 8'h20;
      cyc(1);
      branch_taken = 1'b0;
      cyc(1);
      chk("halt_nobr", {24'h0, inst_address}, 32'd3);
      chk("halt_novalid", {31'h0, instr_valid}, 32'h0);
      ram[3] = 32'h1000_0003;
      pulse_start();
      chk("restart_h", {31'h0, halted}, 32'h0);
      cyc(1);
      chk("restart_pc", {24'h0, instr_pc}, 32'h0);
      chk("restart_v", {31'h0, instr_valid}, 32'h1);

      // Asynchronous reset mid-stream
      cyc(6);
      chk("pre_rst_pc", {24'h0, instr_pc}, 32'd6);
      chk("pre_rst_addr", {24'h0, inst_address}, 32'd7);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", {31'h0, instr_valid}, 32'h0);
      chk("arst_addr", {24'h0, inst_address}, 32'h0);
      chk("arst_pc", {24'h0, instr_pc}, 32'h0);
      chk("arst_count", {16'h0, fetch_count}, 32'h0);
      cyc(2);
      rst = 1'b0;
      cyc(3);
      chk("post_rst_idle", {31'h0, instr_valid}, 32'h0);
      chk("post_rst_addr", {24'h0, inst_address}, 32'h0);
      pulse_start();
      cyc(1);
      chk("resume_pc", {24'h0, instr_pc}, 32'h0);
      chk("resume_v", {31'h0, instr_valid}, 32'h1);
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
